sm_datapath: RTL and testbench
==============================

// Module: sm_datapath
// PURPOSE
//  Datapath for the shift-add sequential multiplier, directly downstream of SMControl.
//  Holds the multiplicand (md), multiplier (mr) and running-sum (rs) registers, and
//  executes SMControl's mdld/mrld/rsclear/rsload/rsshr strobes.
//  Returns mr to the controller. On SMControl's done it captures the product into an
//  output register with a valid/ready handshake.
// PARAMETERS
//  W   4   operand width; product width is 2*W; W=4 when paired with SMControl
// PORTS
//  clk         in   1    clock
//  rst         in   1    synchronous reset, active-high
//  a_in        in   W    multiplicand operand, sampled on mdld
//  b_in        in   W    multiplier operand, sampled on mrld
//  mdld        in   1    load md <= a_in
//  mrld        in   1    load mr <= b_in
//  rsclear     in   1    clear rs and carry
//  rsload      in   1    add md into upper half of rs
//  rsshr       in   1    shift {carry,rs} right by one
//  done        in   1    controller done pulse; capture product
//  mr          out  W    multiplier register, fed to SMControl mr
//  prod        out  2W   captured product
//  prod_valid  out  1    prod holds an unconsumed result
//  prod_ready  in   1    consumer accepts prod when prod_valid&prod_ready
//  prod_drop   out  1    one-cycle pulse: unconsumed result overwritten
//  ctrl_err    out  1    sticky illegal-strobe flag (see CONFIGURATION)
// BEHAVIOUR
//  Reset: md, mr, rs, carry, prod, prod_valid, prod_drop and ctrl_err all go to 0.
//  Every register update occurs on posedge clk, and rst overrides all other inputs.
//  mdld and mrld are independent of each other and of the rs strobes.
//    The new md is visible to an rsload one cycle later.
//  rs strobe priority: rsclear > rsload > rsshr.
//    Only the highest-priority asserted strobe acts in a given cycle.
//  rsclear: rs <= 0, carry <= 0.
//  rsload: {carry, rs[2W-1:W]} <= rs[2W-1:W] + md (W+1-bit sum).
//    rs[W-1:0] is unchanged.
//  rsshr: rs <= {carry, rs[2W-1:1]}, carry <= 0.
//  After W add/shift iterations, rs holds md*mr exactly; there is no truncation.
//  mr is never shifted; the controller inspects mr[i] directly.
//  Output register (all actions take effect the cycle after done is sampled):
//   - done & !prod_valid: prod <= rs, prod_valid <= 1.
//   - prod_valid & prod_ready & !done: prod_valid <= 0.
//   - done & prod_valid & prod_ready: old result is consumed, new result is loaded,
//     prod_valid stays 1, and prod_drop stays 0.
//   - done & prod_valid & !prod_ready: prod <= rs (overwrite) and prod_drop = 1
//     for one cycle.
//   - prod is stable whenever prod_valid=1 and no overwrite occurs.
//  Reset mid-multiply clears everything, including any pending prod_valid.
//    No partial product is ever emitted.
// CONFIGURATION
//  SM_DP_CTRLCHK_EN defined:
//   - ctrl_err is set when two or more of {rsclear, rsload, rsshr} are high in the
//     same cycle, or when rsload/rsshr is high in the same cycle as mdld/mrld.
//   - ctrl_err is sticky until rst.
//   - The priority rule above still applies, so data behaviour is identical.
//  SM_DP_CTRLCHK_EN undefined: the checker logic is absent and ctrl_err is tied to 0.
// TESTING
//  T1: a_in=13, b_in=11, then drive the controller strobe sequence and done.
//      -> prod=143 with prod_valid=1 one cycle after done.
//  T2: a_in=15, b_in=15. -> prod=225 (max value, carry path exercised);
//      a_in=0, b_in=9 -> prod=0.
//  T3: produce a result with prod_ready=0, then pulse done again with a_in=2, b_in=3.
//      -> prod=6 and prod_drop=1 for exactly one cycle.
//  T4: prod_valid=1 with prod_ready=1 in the same cycle as done (a_in=5, b_in=7).
//      -> prod=35, prod_valid stays 1, prod_drop=0.
//  T5: assert rst halfway through a multiply.
//      -> next cycle rs=0, mr=0, prod_valid=0; a following 3*4 run gives prod=12.
//  T6: rsclear & rsload in the same cycle -> rs=0.
//      With SM_DP_CTRLCHK_EN: ctrl_err=1 and it holds until rst.
//      Without the macro: ctrl_err stays 0.

Source files
------------

// File: rtl/sm_datapath.sv
// ============================================================================
//  Module   : sm_datapath
//  Purpose  : Shift-add multiplier datapath (md/mr/rs registers) with a
//             valid/ready product output register. Optional strobe checker
//             enabled by defining SM_DP_CTRLCHK_EN.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module sm_datapath #(
    parameter int W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [W-1:0]     a_in,
    input  logic [W-1:0]     b_in,
    input  logic             mdld,
    input  logic             mrld,
    input  logic             rsclear,
    input  logic             rsload,
    input  logic             rsshr,
    input  logic             done,
    output logic [W-1:0]     mr,
    output logic [2*W-1:0]   prod,
    output logic             prod_valid,
    input  logic             prod_ready,
    output logic             prod_drop,
    output logic             ctrl_err
);

    localparam int c_PW = 2 * W;

    logic [W-1:0]    r_md;
    logic [W-1:0]    r_mr;
    logic [c_PW-1:0] r_rs;
    logic            r_carry;
    logic [c_PW-1:0] r_prod;
    logic            r_prod_valid;
    logic            r_prod_drop;
    logic [W:0]      w_sum;

    // W+1-bit sum so the add into the upper half never loses its carry
    assign w_sum = {1'b0, r_rs[c_PW-1:W]} + {1'b0, r_md};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_md <= '0;
            r_mr <= '0;
        end else begin
            if (mdld) r_md <= a_in;
            if (mrld) r_mr <= b_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rs    <= '0;
            r_carry <= 1'b0;
        end else if (rsclear) begin
            r_rs    <= '0;
            r_carry <= 1'b0;
        end else if (rsload) begin
            {r_carry, r_rs[c_PW-1:W]} <= w_sum;
        end else if (rsshr) begin
            r_rs    <= {r_carry, r_rs[c_PW-1:1]};
            r_carry <= 1'b0;
        end
    end

    // A new result always replaces prod; it is a drop only if the old one was
    // still pending and not being taken in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_prod       <= '0;
            r_prod_valid <= 1'b0;
            r_prod_drop  <= 1'b0;
        end else begin
            r_prod_drop <= 1'b0;
            if (done) begin
                r_prod       <= r_rs;
                r_prod_valid <= 1'b1;
                r_prod_drop  <= r_prod_valid & ~prod_ready;
            end else if (r_prod_valid && prod_ready) begin
                r_prod_valid <= 1'b0;
            end
        end
    end

`ifdef SM_DP_CTRLCHK_EN
    logic r_ctrl_err;
    logic w_rs_multi;
    logic w_ld_conflict;

    assign w_rs_multi    = (rsclear & rsload) | (rsclear & rsshr) | (rsload & rsshr);
    assign w_ld_conflict = (rsload | rsshr) & (mdld | mrld);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ctrl_err <= 1'b0;
        end else if (w_rs_multi || w_ld_conflict) begin
            r_ctrl_err <= 1'b1;
        end
    end

    assign ctrl_err = r_ctrl_err;
`else
    assign ctrl_err = 1'b0;
`endif

    assign mr         = r_mr;
    assign prod       = r_prod;
    assign prod_valid = r_prod_valid;
    assign prod_drop  = r_prod_drop;

endmodule

`default_nettype wire

// File: tb/tb_sm_datapath.sv
// ============================================================================
//  Module   : tb_sm_datapath
//  Purpose  : Directed self-checking bench for sm_datapath.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_sm_datapath;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] a_in, b_in;
    logic       mdld, mrld, rsclear, rsload, rsshr, done;
    logic [3:0] mr;
    logic [7:0] prod;
    logic       prod_valid, prod_ready, prod_drop, ctrl_err;

    int errors = 0;
    int checks = 0;

`ifdef SM_DP_CTRLCHK_EN
    localparam logic c_EXP_ERR = 1'b1;
`else
    localparam logic c_EXP_ERR = 1'b0;
`endif

    sm_datapath #(.W(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .a_in       (a_in),
        .b_in       (b_in),
        .mdld       (mdld),
        .mrld       (mrld),
        .rsclear    (rsclear),
        .rsload     (rsload),
        .rsshr      (rsshr),
        .done       (done),
        .mr         (mr),
        .prod       (prod),
        .prod_valid (prod_valid),
        .prod_ready (prod_ready),
        .prod_drop  (prod_drop),
        .ctrl_err   (ctrl_err)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Controller sequence: load operands, then per bit an optional add and a shift, then done.
    task automatic mult(input logic [3:0] a, input logic [3:0] b, input logic rdy);
        a_in = a; b_in = b; mdld = 1; mrld = 1; rsclear = 1;
        tick;
        mdld = 0; mrld = 0; rsclear = 0;
        for (int i = 0; i < 4; i++) begin
            if (b[i]) begin
                rsload = 1; tick; rsload = 0;
            end
            rsshr = 1; tick; rsshr = 0;
        end
        done = 1; prod_ready = rdy;
        tick;
        done = 0; prod_ready = 0;
    endtask

    task automatic consume;
        prod_ready = 1; tick; prod_ready = 0;
    endtask

    initial begin
        rst = 1; a_in = 0; b_in = 0; mdld = 0; mrld = 0;
        rsclear = 0; rsload = 0; rsshr = 0; done = 0; prod_ready = 0;
        tick; tick;
        rst = 0;
        tick;

        // reset state
        check("rst_mr",    32'(mr), 0);
        check("rst_prod",  32'(prod), 0);
        check("rst_valid", 32'(prod_valid), 0);
        check("rst_drop",  32'(prod_drop), 0);
        check("rst_err",   32'(ctrl_err), 0);

        // T1
        mult(4'd13, 4'd11, 1'b0);
        check("t1_prod",  32'(prod), 143);
        check("t1_valid", 32'(prod_valid), 1);
        check("t1_drop",  32'(prod_drop), 0);
        check("t1_mr",    32'(mr), 11);
        check("t1_err",   32'(ctrl_err), 0);
        consume;
        check("t1_consumed", 32'(prod_valid), 0);

        // T2
        mult(4'd15, 4'd15, 1'b0);
        check("t2_max", 32'(prod), 225);
        consume;
        mult(4'd0, 4'd9, 1'b0);
        check("t2_zero", 32'(prod), 0);
        check("t2_valid", 32'(prod_valid), 1);
        consume;

        // T3
        mult(4'd7, 4'd9, 1'b0);
        check("t3_first", 32'(prod), 63);
        tick;
        check("t3_hold_prod",  32'(prod), 63);
        check("t3_hold_valid", 32'(prod_valid), 1);
        mult(4'd2, 4'd3, 1'b0);
        check("t3_prod",  32'(prod), 6);
        check("t3_drop",  32'(prod_drop), 1);
        check("t3_valid", 32'(prod_valid), 1);
        tick;
        check("t3_drop_pulse", 32'(prod_drop), 0);
        check("t3_prod_hold",  32'(prod), 6);

        // T4
        mult(4'd5, 4'd7, 1'b1);
        check("t4_prod",  32'(prod), 35);
        check("t4_valid", 32'(prod_valid), 1);
        check("t4_drop",  32'(prod_drop), 0);

        // T5: reset partway through 9*13 with 35 still pending
        a_in = 9; b_in = 13; mdld = 1; mrld = 1; rsclear = 1;
        tick;
        mdld = 0; mrld = 0; rsclear = 0;
        rsload = 1; tick; rsload = 0;
        rsshr = 1; tick;
        rst = 1; tick;
        rst = 0; rsshr = 0;
        check("t5_mr",    32'(mr), 0);
        check("t5_valid", 32'(prod_valid), 0);
        check("t5_prod",  32'(prod), 0);
        done = 1; tick; done = 0;
        check("t5_rs_cleared", 32'(prod), 0);
        consume;
        mult(4'd3, 4'd4, 1'b0);
        check("t5_prod12", 32'(prod), 12);
        consume;

        // T6: rsclear beats rsload
        a_in = 5; b_in = 1; mdld = 1; mrld = 1; rsclear = 1;
        tick;
        mdld = 0; mrld = 0; rsclear = 0;
        check("t6_err_before", 32'(ctrl_err), 0);
        rsload = 1; tick;
        rsclear = 1; tick;
        rsclear = 0; rsload = 0;
        done = 1; tick; done = 0;
        check("t6_prod", 32'(prod), 0);
        check("t6_err",  32'(ctrl_err), 32'(c_EXP_ERR));
        consume;

        // rsload beats rsshr
        rsload = 1; rsshr = 1; tick;
        rsload = 0; rsshr = 0;
        done = 1; tick; done = 0;
        check("prio_load_over_shr", 32'(prod), 80);
        check("t6_err_sticky", 32'(ctrl_err), 32'(c_EXP_ERR));
        consume;

        rst = 1; tick; rst = 0;
        check("t6_err_rst", 32'(ctrl_err), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
